cp0_regfile: RTL and testbench
==============================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 Parameter: EXC_ENTRY, 32'hbfc00380, exception handler entry PC driven on exc_target for non-eret exceptions.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
REQ-004 wb_valid  input  1  writeback instruction valid and not flushed; all other requests are ignored when low.
REQ-005 op_mtc0 / op_eret  input  1 each  move-to-CP0 request / exception-return request.
REQ-006 wb_ex  input  1  exception report; wb_excode  input  5  ExcCode; wb_bd  input  1  instruction is in a delay slot.
REQ-007 wb_pc / wb_badvaddr  input  32 each  faulting PC / faulting address.
REQ-008 wb_rd  input  5; wb_sel  input  3  CP0 register select; c0_wdata  input  32  mtc0 data.
REQ-009 ext_int_in  input  6  external interrupt lines, level-sensitive.
REQ-010 c0_rdata  output  32  combinational read of register (wb_rd,wb_sel); 0 for unimplemented registers.
REQ-011 exc_target  output  32  EPC when op_eret, else EXC_ENTRY; has_int  output  1  interrupt pending and enabled.

Function
REQ-012 Implemented registers (rd,sel): BadVAddr(8,0), Count(9,0), Compare(11,0), Status(12,0), Cause(13,0), EPC(14,0).
REQ-013 Status: bit22 BEV read-only 1; IM[15:8] RW; EXL bit1 RW; IE bit0 RW; all other bits read 0.
REQ-014 Cause: BD bit31 RO; TI bit30 RO; IP[15:10] RO hardware; IP[9:8] RW software; ExcCode[6:2] RO; all other bits 0.
REQ-015 Accepted event = wb_valid high; precedence in one cycle: wb_ex > op_eret > op_mtc0; lower-priority requests in the same cycle are dropped.
REQ-016 Exception (wb_ex): Status.EXL<=1; Cause.ExcCode<=wb_excode; when Status.EXL was 0, EPC<=wb_bd ? wb_pc-4 : wb_pc and Cause.BD<=wb_bd; when EXL already 1, EPC and BD unchanged.
REQ-017 Exception with ExcCode 0x04 (AdEL) or 0x05 (AdES): BadVAddr<=wb_badvaddr; other codes leave BadVAddr unchanged.
REQ-018 op_eret: Status.EXL<=0 next edge; exc_target=EPC combinationally in the same cycle.
REQ-019 op_mtc0: writes only RW fields of the selected register next edge; writes to RO fields/unimplemented registers have no effect.
REQ-020 Count: internal 1-bit tick toggles every cycle; Count increments (mod 2^32, wraps 32'hffffffff->0) on cycles where tick=1.
REQ-021 mtc0 to Count loads c0_wdata and overrides that cycle's increment; tick unaffected.
REQ-022 Cause.TI set the cycle after Count==Compare (registered values); mtc0 to Compare clears TI next edge and suppresses setting in that same cycle.
REQ-023 Cause.IP[15:10] registered every cycle from {ext_int_in[5]|TI, ext_int_in[4:0]}.
REQ-024 has_int = |(Cause.IP[15:8] & Status.IM[15:8]) & Status.IE & ~Status.EXL; combinational from registers.
REQ-025 c0_rdata reflects register state before the current edge's update (no write-through bypass).

Reset
REQ-026 resetn low: Status=32'h00400000 (BEV=1, EXL=0, IE=0, IM=0); Cause=0; Count=0; tick=0; Compare, EPC, BadVAddr=0.
REQ-027 Outputs during reset: c0_rdata per reset values, has_int=0, exc_target=EXC_ENTRY unless op_eret (then 0).
REQ-028 resetn asserted mid-operation clears all state immediately regardless of clk; pending requests are lost.

Verification
REQ-029 Syscall: wb_valid=1, wb_ex=1, excode=0x08, pc=32'hbfc01000, bd=0 -> EPC=32'hbfc01000, EXL=1, ExcCode=0x08, exc_target=32'hbfc00380.
REQ-030 Delay slot + nested: ex with pc=32'h80000104, bd=1 -> EPC=32'h80000100, BD=1; second ex pc=32'h80000200 while EXL=1 -> EPC/BD unchanged, ExcCode updated.
REQ-031 mtc0 Status 32'hffffffff then mfc0 -> 32'h0040ff03; mtc0 Cause 32'hffffffff -> only IP[9:8] become 1.
REQ-032 Timer: mtc0 Compare=5, Count=0 -> TI=1 after Count reaches 5; with IM7=1, IE=1, EXL=0 -> has_int=1; mtc0 Compare=100 -> TI=0, has_int=0.
REQ-033 Same-cycle wb_ex and op_mtc0 to EPC=32'h12345678 -> EPC takes exception value; Count=32'hffffffff wraps to 0 after two cycles.
REQ-034 Assert resetn low between clock edges after exception -> Status=32'h00400000, EPC=0 immediately; op_eret then yields exc_target=0.

Source files
------------

// File: rtl/cp0_regfile.sv
// MIPS-style CP0 register file: Status, Cause, EPC, BadVAddr, Count/Compare timer,
// exception/eret sequencing and interrupt-pending generation.
module cp0_regfile #(
    parameter logic [31:0] EXC_ENTRY = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic        op_mtc0,
    input  logic        op_eret,
    input  logic        wb_ex,
    input  logic [4:0]  wb_excode,
    input  logic        wb_bd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_badvaddr,
    input  logic [4:0]  wb_rd,
    input  logic [2:0]  wb_sel,
    input  logic [31:0] c0_wdata,
    input  logic [5:0]  ext_int_in,
    output logic [31:0] c0_rdata,
    output logic [31:0] exc_target,
    output logic        has_int
);
    localparam logic [4:0] RD_BADVADDR = 5'd8;
    localparam logic [4:0] RD_COUNT    = 5'd9;
    localparam logic [4:0] RD_COMPARE  = 5'd11;
    localparam logic [4:0] RD_STATUS   = 5'd12;
    localparam logic [4:0] RD_CAUSE    = 5'd13;
    localparam logic [4:0] RD_EPC      = 5'd14;

    logic [31:0] badvaddr, count, compare, epc;
    logic [7:0]  status_im;
    logic        status_exl, status_ie;
    logic        cause_bd, cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exccode;
    logic        tick;
    logic [31:0] status_val, cause_val;

    // Precedence: exception beats eret beats mtc0; losers are dropped.
    logic ex_ev, eret_ev, mtc0_ev, sel_ok;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc, addr_exc;
    assign ex_ev      = wb_valid & wb_ex;
    assign eret_ev    = wb_valid & op_eret & ~wb_ex;
    assign mtc0_ev    = wb_valid & op_mtc0 & ~wb_ex & ~op_eret;
    assign sel_ok     = (wb_sel == 3'd0);
    assign wr_count   = mtc0_ev & sel_ok & (wb_rd == RD_COUNT);
    assign wr_compare = mtc0_ev & sel_ok & (wb_rd == RD_COMPARE);
    assign wr_status  = mtc0_ev & sel_ok & (wb_rd == RD_STATUS);
    assign wr_cause   = mtc0_ev & sel_ok & (wb_rd == RD_CAUSE);
    assign wr_epc     = mtc0_ev & sel_ok & (wb_rd == RD_EPC);
    assign addr_exc   = (wb_excode == 5'h04) | (wb_excode == 5'h05);

    assign status_val = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_val  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw, 1'b0,
                         cause_exccode, 2'b0};

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im  <= '0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (ex_ev) begin
            status_exl <= 1'b1;
        end else if (eret_ev) begin
            status_exl <= 1'b0;
        end else if (wr_status) begin
            status_im  <= c0_wdata[15:8];
            status_exl <= c0_wdata[1];
            status_ie  <= c0_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cause_bd      <= 1'b0;
            cause_exccode <= '0;
            cause_ip_sw   <= '0;
            cause_ip_hw   <= '0;
            cause_ti      <= 1'b0;
        end else begin
            cause_ip_hw <= {ext_int_in[5] | cause_ti, ext_int_in[4:0]};
            if (ex_ev) begin
                cause_exccode <= wb_excode;
                if (!status_exl) cause_bd <= wb_bd;
            end
            if (wr_cause) cause_ip_sw <= c0_wdata[9:8];
            if (wr_compare)            cause_ti <= 1'b0;
            else if (count == compare) cause_ti <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            epc      <= '0;
            badvaddr <= '0;
            compare  <= '0;
        end else begin
            if (ex_ev && !status_exl) epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
            else if (wr_epc)          epc <= c0_wdata;
            if (ex_ev && addr_exc)    badvaddr <= wb_badvaddr;
            if (wr_compare)           compare <= c0_wdata;
        end
    end

    // Count advances at half the clock rate; a software load wins over the increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick  <= 1'b0;
            count <= '0;
        end else begin
            tick <= ~tick;
            if (wr_count)  count <= c0_wdata;
            else if (tick) count <= count + 32'd1;
        end
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        c0_rdata = '0;
        if (sel_ok) begin
            case (wb_rd)
                RD_BADVADDR: c0_rdata = badvaddr;
                RD_COUNT:    c0_rdata = count;
                RD_COMPARE:  c0_rdata = compare;
                RD_STATUS:   c0_rdata = status_val;
                RD_CAUSE:    c0_rdata = cause_val;
                RD_EPC:      c0_rdata = epc;
                default:     c0_rdata = '0;
            endcase
        end
    end

    assign exc_target = op_eret ? epc : EXC_ENTRY;
    assign has_int    = (|({cause_ip_hw, cause_ip_sw} & status_im)) & status_ie & ~status_exl;
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: table of single-cycle requests with expected
// register reads, plus sequences for the timer, Count wrap and asynchronous reset.
module tb_cp0_regfile;
    localparam logic [31:0] E = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid, op_mtc0, op_eret, wb_ex, wb_bd;
    logic [4:0]  wb_excode, wb_rd;
    logic [2:0]  wb_sel;
    logic [31:0] wb_pc, wb_badvaddr, c0_wdata;
    logic [5:0]  ext_int_in;
    logic [31:0] c0_rdata, exc_target;
    logic        has_int;

    int checks = 0;
    int errors = 0;

    cp0_regfile #(.EXC_ENTRY(E)) dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .op_mtc0(op_mtc0),
        .op_eret(op_eret), .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd),
        .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .wb_rd(wb_rd), .wb_sel(wb_sel),
        .c0_wdata(c0_wdata), .ext_int_in(ext_int_in), .c0_rdata(c0_rdata),
        .exc_target(exc_target), .has_int(has_int)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, ex, eret, mtc0;
        logic [4:0]  excode;
        logic        bd;
        logic [31:0] pc, badvaddr;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic [31:0] wdata, exp_target;
        logic [4:0]  chk_rd;
        logic [2:0]  chk_sel;
        logic [31:0] exp_rdata;
        logic        exp_has_int;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 0; op_mtc0 = 0; op_eret = 0; wb_ex = 0; wb_bd = 0;
        wb_excode = 0; wb_pc = 0; wb_badvaddr = 0; c0_wdata = 0;
    endtask

    task automatic read_reg(input logic [4:0] rd, input logic [2:0] sel, output logic [31:0] d);
        wb_rd = rd; wb_sel = sel;
        #1 d = c0_rdata;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1; op_mtc0 = 1; wb_rd = rd; wb_sel = 0; c0_wdata = d;
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic        found;

        //        v  x  e  m  code   bd pc            badvaddr      rd  sel  wdata          target        crd sel  exp_rdata     hi
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b1,5'h00,1'b0,32'h0,32'h0,5'd11,3'd0,32'hffff0000,E,5'd11,3'd0,32'hffff0000,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,E,5'd13,3'd0,32'h00000000,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,5'h08,1'b0,32'hbfc01000,32'h0,5'd0,3'd0,32'h0,E,5'd14,3'd0,32'hbfc01000,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,E,5'd12,3'd0,32'h00400002,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,E,5'd13,3'd0,32'h00000020,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,32'hbfc01000,5'd12,3'd0,32'h00400000,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,5'h04,1'b1,32'h80000104,32'hdeadbeef,5'd0,3'd0,32'h0,E,5'd14,3'd0,32'h80000100,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,E,5'd13,3'd0,32'h80000010,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,E,5'd8,3'd0,32'hdeadbeef,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,5'h0c,1'b0,32'h80000200,32'h0,5'd0,3'd0,32'h0,E,5'd14,3'd0,32'h80000100,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,E,5'd13,3'd0,32'h80000030,1'b0};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0,5'h0a,1'b0,32'h80000300,32'h55555555,5'd0,3'd0,32'h0,E,5'd8,3'd0,32'hdeadbeef,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b1,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,32'h80000100,5'd12,3'd0,32'h00400000,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b1,5'h00,1'b0,32'h0,32'h0,5'd12,3'd0,32'hffffffff,E,5'd12,3'd0,32'h0040ff03,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b1,5'h00,1'b0,32'h0,32'h0,5'd13,3'd0,32'hffffffff,E,5'd13,3'd0,32'h80000328,1'b0};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b1,5'h00,1'b0,32'h0,32'h0,5'd12,3'd0,32'h00000301,E,5'd12,3'd0,32'h00400301,1'b1};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b1,5'h00,1'b0,32'h0,32'h0,5'd13,3'd0,32'h00000000,E,5'd13,3'd0,32'h80000028,1'b0};
        vecs[17] = '{1'b0,1'b1,1'b0,1'b0,5'h08,1'b0,32'h11111110,32'h0,5'd0,3'd0,32'h0,E,5'd14,3'd0,32'h80000100,1'b0};
        vecs[18] = '{1'b1,1'b1,1'b0,1'b1,5'h08,1'b0,32'hbfc02000,32'h0,5'd14,3'd0,32'h12345678,E,5'd14,3'd0,32'hbfc02000,1'b0};
        vecs[19] = '{1'b1,1'b0,1'b1,1'b1,5'h00,1'b0,32'h0,32'h0,5'd14,3'd0,32'haaaa0000,32'hbfc02000,5'd14,3'd0,32'hbfc02000,1'b0};
        vecs[20] = '{1'b0,1'b0,1'b0,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,E,5'd12,3'd0,32'h00400301,1'b0};
        vecs[21] = '{1'b1,1'b0,1'b0,1'b1,5'h00,1'b0,32'h0,32'h0,5'd14,3'd1,32'hffffffff,E,5'd14,3'd0,32'hbfc02000,1'b0};
        vecs[22] = '{1'b0,1'b0,1'b0,1'b0,5'h00,1'b0,32'h0,32'h0,5'd0,3'd0,32'h0,E,5'd14,3'd1,32'h00000000,1'b0};

        // Reset-time outputs.
        resetn = 0; ext_int_in = 0; wb_rd = 0; wb_sel = 0;
        idle_inputs();
        #3;
        read_reg(12, 0, d); check("rst_status", d, 32'h00400000);
        read_reg(13, 0, d); check("rst_cause", d, 32'h0);
        read_reg(9, 0, d);  check("rst_count", d, 32'h0);
        check("rst_has_int", {31'b0, has_int}, 32'h0);
        check("rst_target", exc_target, E);
        op_eret = 1;
        #1 check("rst_eret_target", exc_target, 32'h0);
        op_eret = 0;
        @(negedge clk);
        resetn = 1;

        for (int i = 0; i < 23; i++) begin
            wb_valid = vecs[i].valid; wb_ex = vecs[i].ex; op_eret = vecs[i].eret;
            op_mtc0 = vecs[i].mtc0; wb_excode = vecs[i].excode; wb_bd = vecs[i].bd;
            wb_pc = vecs[i].pc; wb_badvaddr = vecs[i].badvaddr; wb_rd = vecs[i].rd;
            wb_sel = vecs[i].sel; c0_wdata = vecs[i].wdata;
            #1 check($sformatf("vec%0d_target", i), exc_target, vecs[i].exp_target);
            @(posedge clk);
            #2 idle_inputs();
            read_reg(vecs[i].chk_rd, vecs[i].chk_sel, d);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            check($sformatf("vec%0d_has_int", i), {31'b0, has_int}, {31'b0, vecs[i].exp_has_int});
            @(negedge clk);
        end

        // Timer interrupt through IM7.
        mtc0(12, 32'h00008001);
        mtc0(11, 32'd5);
        mtc0(9, 32'd0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            read_reg(13, 0, d);
            if (d[30]) found = 1;
            else cycle();
        end
        check("timer_ti_set", {31'b0, found}, 32'h1);
        read_reg(9, 0, d); check("timer_count_at_ti", d, 32'd5);
        cycle();
        check("timer_has_int", {31'b0, has_int}, 32'h1);
        mtc0(11, 32'd100);
        read_reg(13, 0, d); check("timer_ti_clear", {31'b0, d[30]}, 32'h0);
        cycle();
        check("timer_has_int_clear", {31'b0, has_int}, 32'h0);

        // Count wraps.
        mtc0(9, 32'hffffffff);
        cycle();
        cycle();
        read_reg(9, 0, d); check("count_wrap", d, 32'h0);

        // Asynchronous reset between edges.
        wb_valid = 1; wb_ex = 1; wb_excode = 5'h08; wb_pc = 32'h80001000;
        @(posedge clk);
        #1 idle_inputs();
        read_reg(14, 0, d); check("pre_reset_epc", d, 32'h80001000);
        #2 resetn = 0;
        read_reg(12, 0, d); check("async_rst_status", d, 32'h00400000);
        read_reg(14, 0, d); check("async_rst_epc", d, 32'h0);
        op_eret = 1;
        #1 check("async_rst_eret_target", exc_target, 32'h0);
        check("async_rst_has_int", {31'b0, has_int}, 32'h0);
        op_eret = 0;
        @(negedge clk);
        resetn = 1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
